j2c_master_stream: RTL and testbench
====================================

// Module: j2c_master_stream
// PURPOSE
//  Parametrised J2C serial master: next generation of the single-message master.
//  Serialises MESSAGE_LENGTH-bit words from a valid/ready source onto sda/scl.
//  Adds configurable bit rate, bit order, optional parity and multi-word frames.
//  Sits between the host data path and the J2C bus pins.
// PARAMETERS
//  MESSAGE_LENGTH  8  data bits per word (>=1)
//  CLK_DIV         2  clk cycles per scl half-period H (>=1)
//  MSB_FIRST       1  1: data[MESSAGE_LENGTH-1] sent first; 0: data[0] first
//  PARITY_EN       0  1: append even-parity bit (^data) after each word
// PORTS
//  clk    in   1               system clock, all logic on posedge
//  reset  in   1               synchronous, active-low; clears all state
//  data   in   MESSAGE_LENGTH  word to send, sampled on valid&&ready
//  valid  in   1               source has a word
//  last   in   1               word closes the frame (sampled with data)
//  ready  out  1               master accepts a word this cycle
//  busy   out  1               frame in progress (START..STOP_HIGH, HOLD)
//  done   out  1               1-cycle pulse when a frame completes
//  sda    out  1               serial data line
//  scl    out  1               serial clock line
// BEHAVIOUR
//  Reset (reset==0 at posedge): state IDLE, sda=1, scl=1, ready=1, busy=0,
//   done=0, bit/divider counters 0, shift register 0. Overrides any state,
//   including mid-frame: lines go high next edge, no STOP is generated.
//  N = MESSAGE_LENGTH+PARITY_EN bits per word; H = CLK_DIV cycles per phase.
//  States (each timed phase lasts exactly H cycles; divider restarts per phase):
//   IDLE      sda=1 scl=1 ready=1. valid -> latch data,last; -> START.
//   START     sda=0 scl=1 (start condition). -> BIT_LOW, bit index 0.
//   BIT_LOW   scl=0, sda=current bit, updated on phase entry. -> BIT_HIGH.
//   BIT_HIGH  scl=1, sda stable. Index<N-1: index++ -> BIT_LOW.
//             Index==N-1: latched last=1 -> STOP_LOW; last=0 -> HOLD.
//   HOLD      scl=0, sda=0, ready=1, untimed (bus stretch). valid -> latch
//             data,last; -> BIT_LOW index 0 (no repeated start).
//   STOP_LOW  scl=0 sda=0. -> STOP_HIGH.
//   STOP_HIGH scl=1 sda=0. -> IDLE; sda rises on IDLE entry, done=1 that cycle.
//  ready=1 only in IDLE and HOLD; ready is a registered output, the accept
//   edge drops it next cycle. valid with ready=0 is ignored (source holds it).
//  data/last changes while not accepting have no effect (latched copy used).
//  Parity bit = XOR of latched data; sent after the last data bit.
//  Latency: accept in IDLE -> sda falls 1 cycle later. Single-word frame:
//   accept to done = H*(2N+3) cycles (defaults: 2*19 = 38).
//  sda never changes while scl=1 except START and STOP edges.
//  done, busy registered; busy=0 exactly in IDLE.
// STRUCTURE
//  Shared package j2c_pkg: state encoding typedef (IDLE, START, BIT_LOW,
//   BIT_HIGH, HOLD, STOP_LOW, STOP_HIGH) and default MESSAGE_LENGTH.
//  One sub-module: j2c_clk_div (phase timer, tick after CLK_DIV cycles,
//   restart input); FSM, shift register and bit counter stay in top.
// TESTING
//  1 Reset held 3 cycles mid-BIT_HIGH -> next edge sda=1 scl=1 ready=1 busy=0.
//  2 Defaults, data=8'h5F last=1 -> sda during BIT_HIGH = 0,1,0,1,1,1,1,1;
//    done 38 cycles after accept; START/STOP edges with scl=1.
//  3 MSB_FIRST=0, PARITY_EN=1, data=8'h95 -> bits 1,0,1,0,1,0,0,1 then parity 0.
//  4 Frame 8'hF0 last=0, valid withheld 20 cycles, then 8'h0F last=1 ->
//    scl=0 and ready=1 throughout HOLD; no start between words; one done.
//  5 CLK_DIV=5 -> every scl high/low phase exactly 5 cycles; valid during
//    BIT phases with changing data ignored.
//  6 Checker throughout: sda stable while scl=1 outside START/STOP.

Source files
------------

// File: rtl/j2c_pkg.sv
// Shared definitions for the J2C stream master: state encoding and the
// line levels each state drives onto the bus.
package j2c_pkg;

  localparam int DEFAULT_MESSAGE_LENGTH = 8;

  typedef enum logic [2:0] {
    IDLE,
    START,
    BIT_LOW,
    BIT_HIGH,
    HOLD,
    STOP_LOW,
    STOP_HIGH
  } state_t;

  // IDLE and HOLD wait on the source; every other state lasts one divider phase.
  function automatic logic is_timed(input state_t s);
    return !(s inside {IDLE, HOLD});
  endfunction

  function automatic logic scl_level(input state_t s);
    return !(s inside {BIT_LOW, HOLD, STOP_LOW});
  endfunction

  function automatic logic sda_level(input state_t s, input logic bit_value);
    case (s)
      IDLE:              return 1'b1;
      BIT_LOW, BIT_HIGH: return bit_value;
      default:           return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/j2c_clk_div.sv
// Phase timer: pulses tick on the CLK_DIV-th cycle of a phase and starts
// over; restart holds it at the beginning of a phase.
module j2c_clk_div #(
  parameter int CLK_DIV = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic restart,
  output logic tick
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [CW-1:0] count;

  assign tick = !restart && (count == CW'(CLK_DIV - 1));

  // NOTE: sequential state uses <= so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!reset) begin
      count <= '0;
    end else if (restart || tick) begin
      count <= '0;
    end else begin
      count <= count + CW'(1);
    end
  end

endmodule

// File: rtl/j2c_master_stream.sv
// J2C serial master: serialises valid/ready words into START, data bits,
// optional even parity, HOLD between words of a frame, and STOP.
module j2c_master_stream
  import j2c_pkg::*;
#(
  parameter int MESSAGE_LENGTH = DEFAULT_MESSAGE_LENGTH,
  parameter int CLK_DIV        = 2,
  parameter int MSB_FIRST      = 1,
  parameter int PARITY_EN      = 0
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [MESSAGE_LENGTH-1:0] data,
  input  logic                      valid,
  input  logic                      last,
  output logic                      ready,
  output logic                      busy,
  output logic                      done,
  output logic                      sda,
  output logic                      scl
);

  localparam int N  = MESSAGE_LENGTH + ((PARITY_EN != 0) ? 1 : 0);
  localparam int BW = $clog2(N + 1);

  state_t         state, state_d;
  logic [N-1:0]   shreg, shreg_d;
  logic [BW-1:0]  bit_idx, bit_idx_d;
  logic           last_q, last_d;
  logic           tick;
  logic           accept;

  // Word laid out so the first bit on the wire sits in the top position.
  function automatic logic [N-1:0] frame_word(input logic [MESSAGE_LENGTH-1:0] d);
    logic [N-1:0]              w;
    logic [MESSAGE_LENGTH-1:0] ordered;
    for (int i = 0; i < MESSAGE_LENGTH; i++) begin
      ordered[i] = (MSB_FIRST != 0) ? d[i] : d[MESSAGE_LENGTH-1-i];
    end
    w = '0;
    w[N-1 -: MESSAGE_LENGTH] = ordered;
    if (PARITY_EN != 0) w[0] = ^d;
    return w;
  endfunction

  assign accept = valid && ready;

  j2c_clk_div #(.CLK_DIV(CLK_DIV)) u_clk_div (
    .clk     (clk),
    .reset   (reset),
    .restart (!is_timed(state)),
    .tick    (tick)
  );

  always_comb begin
    // NOTE: every variable gets a default first, so no path infers a latch.
    state_d   = state;
    shreg_d   = shreg;
    bit_idx_d = bit_idx;
    last_d    = last_q;
    unique case (state)
      IDLE: if (accept) begin
        shreg_d = frame_word(data);
        last_d  = last;
        state_d = START;
      end
      START: if (tick) begin
        bit_idx_d = '0;
        state_d   = BIT_LOW;
      end
      BIT_LOW: if (tick) state_d = BIT_HIGH;
      BIT_HIGH: if (tick) begin
        if (bit_idx == BW'(N - 1)) begin
          state_d = last_q ? STOP_LOW : HOLD;
        end else begin
          bit_idx_d = bit_idx + BW'(1);
          shreg_d   = shreg << 1;
          state_d   = BIT_LOW;
        end
      end
      // Next word continues the frame directly, without a repeated start.
      HOLD: if (accept) begin
        shreg_d   = frame_word(data);
        last_d    = last;
        bit_idx_d = '0;
        state_d   = BIT_LOW;
      end
      STOP_LOW:  if (tick) state_d = STOP_HIGH;
      STOP_HIGH: if (tick) state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  // Line and handshake outputs are registered from the next state so they
  // change on the same edge as the state itself.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state   <= IDLE;
      shreg   <= '0;
      bit_idx <= '0;
      last_q  <= 1'b0;
      sda     <= 1'b1;
      scl     <= 1'b1;
      ready   <= 1'b1;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state   <= state_d;
      shreg   <= shreg_d;
      bit_idx <= bit_idx_d;
      last_q  <= last_d;
      sda     <= sda_level(state_d, shreg_d[N-1]);
      scl     <= scl_level(state_d);
      ready   <= (state_d inside {IDLE, HOLD});
      busy    <= (state_d != IDLE);
      done    <= (state == STOP_HIGH) && (state_d == IDLE);
    end
  end

endmodule

// File: tb/tb_j2c_master_stream.sv
// Bench for j2c_master_stream: three configurations, a bus-level monitor
// that decodes frames, and a word-level model of the expected bit stream.
module tb_j2c_master_stream;

  localparam int NI = 3;
  localparam int DIV  [NI] = '{2, 2, 5};
  localparam int MSBF [NI] = '{1, 0, 1};
  localparam int PAR  [NI] = '{0, 1, 0};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n;
  logic [7:0]    data [NI];
  logic [NI-1:0] valid, last;
  wire  [NI-1:0] ready, busy, done, sda, scl;

  for (genvar k = 0; k < NI; k++) begin : g_dut
    j2c_master_stream #(
      .MESSAGE_LENGTH (8),
      .CLK_DIV        (DIV[k]),
      .MSB_FIRST      (MSBF[k]),
      .PARITY_EN      (PAR[k])
    ) u_dut (
      .clk   (clk),
      .reset (rst_n),
      .data  (data[k]),
      .valid (valid[k]),
      .last  (last[k]),
      .ready (ready[k]),
      .busy  (busy[k]),
      .done  (done[k]),
      .sda   (sda[k]),
      .scl   (scl[k])
    );
  end

  int checks = 0;
  int passes = 0;
  int cyc    = 0;

  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
  endtask

  // Bus monitor: bits are sampled on scl rising edges, so every frame
  // yields its data/parity bits followed by one STOP_HIGH sample.
  logic [63:0]   mon_bits   [NI] = '{default: '0};
  int            mon_cnt    [NI] = '{default: 0};
  int            mon_starts [NI] = '{default: 0};
  int            mon_dones  [NI] = '{default: 0};
  int            run_len    [NI] = '{default: 0};
  logic          run_ok     [NI] = '{default: 1'b0};
  int            viol       = 0;
  int            phase_viol = 0;
  logic [NI-1:0] p_scl  = '1;
  logic [NI-1:0] p_sda  = '1;
  logic [NI-1:0] p_busy = '0;
  logic          p_rst  = 1'b0;

  always @(negedge clk) begin
    for (int k = 0; k < NI; k++) begin
      if (rst_n && p_rst) begin
        if (!p_scl[k] && scl[k]) begin
          mon_bits[k] = {mon_bits[k][62:0], sda[k]};
          mon_cnt[k]++;
        end
        if (p_scl[k] && scl[k] && p_sda[k] && !sda[k] && !p_busy[k] && busy[k]) mon_starts[k]++;
        if (done[k]) mon_dones[k]++;
        if (p_scl[k] && scl[k] && (sda[k] != p_sda[k])) begin
          if (!((!p_busy[k] && busy[k] && !sda[k]) || (done[k] && sda[k]))) viol++;
        end
        if (scl[k] != p_scl[k]) begin
          if (k == 2 && run_ok[k] && p_busy[k] && run_len[k] != DIV[k]) phase_viol++;
          run_len[k] = 1;
          run_ok[k]  = busy[k];
        end else begin
          run_len[k]++;
        end
        if (!busy[k]) run_ok[k] = 1'b0;
      end else begin
        run_len[k] = 0;
        run_ok[k]  = 1'b0;
      end
    end
    p_scl  = scl;
    p_sda  = sda;
    p_busy = busy;
    p_rst  = rst_n;
  end

  // Reference model: the bit sequence a word contributes to the wire.
  task automatic add_word(input int k, input logic [7:0] d,
                          inout logic [63:0] s, inout int n);
    for (int i = 0; i < 8; i++) begin
      s = {s[62:0], (MSBF[k] != 0) ? d[7-i] : d[i]};
      n++;
    end
    if (PAR[k] != 0) begin
      s = {s[62:0], ^d};
      n++;
    end
  endtask

  int base_cnt, base_starts, base_dones;

  task automatic snap(input int k);
    @(negedge clk);
    #1;
    base_cnt    = mon_cnt[k];
    base_starts = mon_starts[k];
    base_dones  = mon_dones[k];
  endtask

  // Presents a word, waits for the handshake, returns the cycle count
  // seen just before the accepting edge. Data is scrambled afterwards.
  task automatic send_word(input int k, input logic [7:0] d, input logic l, output int acc);
    int n;
    n        = 0;
    acc      = -1;
    data[k]  = d;
    last[k]  = l;
    valid[k] = 1'b1;
    while (!ready[k] && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (!ready[k]) begin
      check("ready_timeout", 0, 1);
      valid[k] = 1'b0;
      return;
    end
    acc = cyc;
    @(negedge clk);
    valid[k] = 1'b0;
    data[k]  = 8'($urandom);
    last[k]  = 1'($urandom);
  endtask

  task automatic wait_done(input int k, input int acc, output int lat);
    int n;
    n = 0;
    while (!done[k] && n < 1000) begin
      @(negedge clk);
      n++;
    end
    if (!done[k]) begin
      check("done_timeout", 0, 1);
      lat = -1;
    end else begin
      lat = cyc - acc - 1;
    end
  endtask

  task automatic check_frame(input int k, input string name,
                             input logic [63:0] exp, input int exp_n);
    logic [63:0] mask;
    #1;
    mask = (64'd1 << exp_n) - 64'd1;
    check({name, "_nbits"},  64'(mon_cnt[k] - base_cnt - 1), 64'(exp_n));
    check({name, "_bits"},   (mon_bits[k] >> 1) & mask, exp & mask);
    check({name, "_starts"}, 64'(mon_starts[k] - base_starts), 64'd1);
    check({name, "_dones"},  64'(mon_dones[k] - base_dones), 64'd1);
  endtask

  typedef struct {
    int         k;
    logic [7:0] d;
    logic [8:0] bits;
    int         nb;
    int         lat;
  } vec_t;

  initial begin
    vec_t        tbl [3];
    int          acc, lat, n, bad, nw;
    logic [63:0] exp;
    logic [7:0]  d;

    tbl[0] = '{k: 0, d: 8'h5F, bits: 9'b0_0101_1111, nb: 8, lat: 38};
    tbl[1] = '{k: 1, d: 8'h95, bits: 9'b1_0101_0010, nb: 9, lat: 42};
    tbl[2] = '{k: 2, d: 8'hA5, bits: 9'b0_1010_0101, nb: 8, lat: 95};

    rst_n = 1'b0;
    valid = '0;
    last  = '0;
    for (int k = 0; k < NI; k++) data[k] = '0;
    repeat (3) @(negedge clk);
    for (int k = 0; k < NI; k++)
      check($sformatf("reset_lines%0d", k), {sda[k], scl[k], ready[k], busy[k], done[k]}, 5'b11100);
    rst_n = 1'b1;

    // Single-word frames per configuration: bit order, parity, latency.
    foreach (tbl[i]) begin
      snap(tbl[i].k);
      send_word(tbl[i].k, tbl[i].d, 1'b1, acc);
      check($sformatf("start_lines%0d", i), {sda[tbl[i].k], scl[tbl[i].k], busy[tbl[i].k]}, 3'b011);
      wait_done(tbl[i].k, acc, lat);
      check($sformatf("latency%0d", i), 64'(lat), 64'(tbl[i].lat));
      check($sformatf("stop_lines%0d", i), {sda[tbl[i].k], scl[tbl[i].k], busy[tbl[i].k]}, 3'b110);
      check_frame(tbl[i].k, $sformatf("vec%0d", i), 64'(tbl[i].bits), tbl[i].nb);
    end

    // Reset asserted for 3 cycles while scl is high in a data bit.
    snap(0);
    send_word(0, 8'h3C, 1'b1, acc);
    n = 0;
    while (!(mon_cnt[0] - base_cnt >= 3 && scl[0] && busy[0]) && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("reset_reach_bit_high", 64'(scl[0] && busy[0]), 64'd1);
    rst_n = 1'b0;
    @(negedge clk);
    check("reset_mid_frame", {sda[0], scl[0], ready[0], busy[0], done[0]}, 5'b11100);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("reset_released", {sda[0], scl[0], ready[0], busy[0], done[0]}, 5'b11100);
    base_dones = mon_dones[0];
    repeat (60) @(negedge clk);
    #1;
    check("reset_no_done", 64'(mon_dones[0] - base_dones), 64'd0);

    // Two-word frame with a 20-cycle bus stretch between words.
    snap(0);
    send_word(0, 8'hF0, 1'b0, acc);
    n = 0;
    while (!ready[0] && n < 200) begin
      @(negedge clk);
      n++;
    end
    bad = 0;
    repeat (20) begin
      if (scl[0] !== 1'b0 || ready[0] !== 1'b1 || busy[0] !== 1'b1) bad++;
      @(negedge clk);
    end
    check("hold_lines", 64'(bad), 64'd0);
    send_word(0, 8'h0F, 1'b1, acc);
    wait_done(0, acc, lat);
    check_frame(0, "hold_frame", 64'hF00F, 16);

    // CLK_DIV=5: valid held with changing data while the frame runs.
    snap(2);
    data[2]  = 8'hC3;
    last[2]  = 1'b1;
    valid[2] = 1'b1;
    acc      = cyc;
    @(negedge clk);
    bad = 0;
    repeat (80) begin
      data[2] = 8'($urandom);
      last[2] = 1'($urandom);
      if (ready[2] !== 1'b0) bad++;
      @(negedge clk);
    end
    valid[2] = 1'b0;
    check("busy_ignores_valid", 64'(bad), 64'd0);
    wait_done(2, acc, lat);
    check("div5_latency", 64'(lat), 64'd95);
    check_frame(2, "div5_frame", 64'hC3, 8);

    // Randomised multi-word frames against the word-level model.
    for (int k = 0; k < 2; k++) begin
      for (int f = 0; f < 5; f++) begin
        snap(k);
        exp = '0;
        n   = 0;
        nw  = $urandom_range(1, 3);
        for (int w = 0; w < nw; w++) begin
          d = 8'($urandom);
          add_word(k, d, exp, n);
          send_word(k, d, (w == nw - 1), acc);
          repeat ($urandom_range(0, 8)) @(negedge clk);
        end
        wait_done(k, acc, lat);
        check_frame(k, $sformatf("rand_k%0d_f%0d", k, f), exp, n);
      end
    end

    repeat (5) @(negedge clk);
    check("sda_stable_scl_high", 64'(viol), 64'd0);
    check("phase_len_div5", 64'(phase_viol), 64'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
